vrms_bcd_convert: RTL and testbench
===================================

# vrms_bcd_convert

Downstream display-formatting stage for the auto-ranging Vrms measurement path. It watches the 24-bit range-tagged result word from the range controller and starts a conversion whenever that word changes. Each conversion turns the 22-bit magnitude into 7 packed BCD digits with a sequential double-dabble engine. It then presents the digits, the decimal-point position and the range code to the display driver with a one-cycle valid strobe, and enforces a minimum hold time between updates to suppress display flicker.

## Interface
Parameters:
- HOLD_CYCLES, 24'd2_500_000: minimum number of clk_sys cycles spent in IDLE after a result before the next capture.
- DP_HI, 3'd3: dp_pos value when data_in[23] = 0 (high range).
- DP_LO, 3'd4: dp_pos value when data_in[23] = 1 (low range).

Ports:
- clk_sys, input, 1: system clock; the only clock.
- rst, input, 1: asynchronous, active-high reset.
- data_in, input, 24: result word from the range controller. [23:22] is the range code; [21:0] is the unsigned magnitude. The word carries no strobe and is treated as level data.
- bcd_out, output, 28: 7 packed BCD digits; [3:0] is the least significant digit.
- dp_pos, output, 3: decimal-point position, counted as a digit index from the LSB.
- range_out, output, 2: range code latched with the displayed value.
- bcd_valid, output, 1: one-cycle pulse; the new bcd_out, dp_pos and range_out are valid in the same cycle.
- busy, output, 1: high from the capture edge until the DONE edge, exclusive.

## Operation
- Internal registers:
  - last_val[23:0]: last captured word.
  - shreg: a 22-bit binary part plus a 28-bit BCD part.
  - iter[4:0]: shift-iteration counter.
  - hold_cnt[23:0]: hold-time counter.
- Reset, asynchronous: state = IDLE and all registers clear. Outputs go to bcd_out = 0, dp_pos = 0, range_out = 0, bcd_valid = 0, busy = 0.
- Because last_val = 0 after reset, data_in = 0 does not trigger a conversion. The displayed 0 is already correct in that case.
- IDLE:
  - If hold_cnt != 0, decrement hold_cnt each cycle.
  - If hold_cnt == 0 and data_in != last_val: load last_val = data_in, binary part = data_in[21:0], BCD part = 0, iter = 0, set busy, go to SHIFT.
- SHIFT, 22 cycles:
  - Each cycle, add 3 to every BCD nibble that is >= 5, then shift the whole {BCD, binary} register left by 1. Both steps complete within one cycle.
  - Increment iter. When iter == 21, go to DONE.
- DONE, 1 cycle:
  - bcd_out <= BCD part; range_out <= last_val[23:22]; dp_pos <= last_val[23] ? DP_LO : DP_HI.
  - bcd_valid <= 1 for exactly one cycle.
  - busy <= 0; hold_cnt <= HOLD_CYCLES; go to IDLE.
- Changes on data_in while in SHIFT or DONE are ignored. After the hold time expires, the current data_in is compared with last_val. Intermediate values that came and went are never converted.
- Arithmetic: the 22-bit maximum of 4,194,303 needs exactly 7 digits, so there is no overflow path. Only range codes 00 and 10 are produced upstream. Codes 01 and 11 are passed through on range_out unchanged and use dp_pos per bit 23.

## Timing
- Let E0 be the capture edge, i.e. the first edge in IDLE with hold_cnt == 0 and data_in != last_val.
  - SHIFT occupies E1..E22.
  - The DONE edge is E23; bcd_valid is high between E23 and E24.
  - busy is high between E0 and E23.
- Latency is 23 cycles from the capture edge to the valid output.
- The earliest next capture edge is E23 + HOLD_CYCLES + 1. With HOLD_CYCLES = 0, conversions can run back-to-back, with a capture at E24.
- Outputs hold their values between bcd_valid pulses.
- Reset asserted mid-SHIFT clears everything at once, with no bcd_valid pulse. After release, a nonzero data_in is re-converted because last_val = 0.

## Test plan
- Reset, then hold data_in = 24'h000000 for 200 cycles -> bcd_valid never asserts, and bcd_out = 0, busy = 0 throughout.
- HOLD_CYCLES = 4; data_in = {2'b00, 22'd13141} -> busy for 23 cycles, then bcd_valid pulse with bcd_out = 28'h0013141, dp_pos = 3, range_out = 2'b00.
- data_in = {2'b10, 22'd4194303} -> bcd_out = 28'h4194303, dp_pos = 4, range_out = 2'b10; bcd_valid is exactly one cycle wide.
- Start a conversion of 22'd100, then change data_in to 22'd999 at SHIFT cycle 10 -> first pulse gives 28'h0000100, second pulse gives 28'h0000999. The second capture occurs exactly HOLD_CYCLES + 1 cycles after the first DONE edge.
- HOLD_CYCLES = 100; change data_in one cycle after a bcd_valid -> the next busy rise comes no earlier than 101 cycles after the preceding DONE edge.
- Assert rst at SHIFT cycle 12 with data_in = {2'b00, 22'd5000} -> all outputs are 0 immediately and no bcd_valid occurs. After release, one conversion runs and yields 28'h0005000.

Source files
------------

// File: rtl/vrms_bcd_convert.sv
// Display-formatting stage: converts the 22-bit Vrms magnitude to 7 packed BCD digits
// using a sequential double-dabble engine, with a hold-off between display updates.
module vrms_bcd_convert #(
   parameter logic [23:0] HOLD_CYCLES = 24'd2_500_000,
   parameter logic [2:0]  DP_HI       = 3'd3,
   parameter logic [2:0]  DP_LO       = 3'd4
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic [23:0] data_in,
   output logic [27:0] bcd_out,
   output logic [2:0]  dp_pos,
   output logic [1:0]  range_out,
   output logic        bcd_valid,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [23:0] lastVal_q, lastVal_d;
   logic [49:0] shreg_q, shreg_d;
   logic [4:0]  iter_q, iter_d;
   logic [23:0] holdCnt_q, holdCnt_d;
   logic [27:0] bcd_q, bcd_d;
   logic [2:0]  dp_q, dp_d;
   logic [1:0]  range_q, range_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic [27:0] bcdAdj;

   // Add-3 correction on every BCD nibble of 5 or more, applied before each shift.
   always_comb begin
      bcdAdj = shreg_q[49:22];
      for (int i = 0; i < 7; i++) begin
         if (shreg_q[22 + 4*i +: 4] >= 4'd5) begin
            bcdAdj[4*i +: 4] = shreg_q[22 + 4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      lastVal_d = lastVal_q;
      shreg_d   = shreg_q;
      iter_d    = iter_q;
      holdCnt_d = holdCnt_q;
      bcd_d     = bcd_q;
      dp_d      = dp_q;
      range_d   = range_q;
      valid_d   = 1'b0;
      busy_d    = busy_q;
      case (state_q)
         IDLE: begin
            if (holdCnt_q != 24'd0) begin
               holdCnt_d = holdCnt_q - 24'd1;
            end else if (data_in != lastVal_q) begin
               lastVal_d = data_in;
               shreg_d   = {28'd0, data_in[21:0]};
               iter_d    = 5'd0;
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d = {bcdAdj[26:0], shreg_q[21:0], 1'b0};
            iter_d  = iter_q + 5'd1;
            if (iter_q == 5'd21) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d     = shreg_q[49:22];
            range_d   = lastVal_q[23:22];
            dp_d      = lastVal_q[23] ? DP_LO : DP_HI;
            valid_d   = 1'b1;
            busy_d    = 1'b0;
            holdCnt_d = HOLD_CYCLES;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         lastVal_q <= 24'd0;
         shreg_q   <= 50'd0;
         iter_q    <= 5'd0;
         holdCnt_q <= 24'd0;
         bcd_q     <= 28'd0;
         dp_q      <= 3'd0;
         range_q   <= 2'd0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lastVal_q <= lastVal_d;
         shreg_q   <= shreg_d;
         iter_q    <= iter_d;
         holdCnt_q <= holdCnt_d;
         bcd_q     <= bcd_d;
         dp_q      <= dp_d;
         range_q   <= range_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign bcd_out   = bcd_q;
   assign dp_pos    = dp_q;
   assign range_out = range_q;
   assign bcd_valid = valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_vrms_bcd_convert.sv
// Scoreboard bench for vrms_bcd_convert: expected display words are queued at stimulus time
// and popped by an independent monitor whenever bcd_valid pulses.
module tb_vrms_bcd_convert;

   localparam logic [23:0] HOLD = 24'd4;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] data_in = 24'd0;
   logic [27:0] bcd_out;
   logic [2:0]  dp_pos;
   logic [1:0]  range_out;
   logic        bcd_valid;
   logic        busy;

   typedef struct packed {
      logic [27:0] bcd;
      logic [2:0]  dp;
      logic [1:0]  rng;
   } exp_t;

   exp_t        expQ[$];
   logic [27:0] lastBcd = 28'd0;
   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;

   vrms_bcd_convert #(
      .HOLD_CYCLES(HOLD),
      .DP_HI(3'd3),
      .DP_LO(3'd4)
   ) dut (
      .clk_sys(clk_sys),
      .rst(rst),
      .data_in(data_in),
      .bcd_out(bcd_out),
      .dp_pos(dp_pos),
      .range_out(range_out),
      .bcd_valid(bcd_valid),
      .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   initial begin
      #500_000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passes);
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: decimal digits via plain division, decimal point chosen by range bit 23.
   function automatic exp_t model(logic [23:0] w);
      int unsigned v;
      exp_t e;
      v = int'(w[21:0]);
      for (int i = 0; i < 7; i++) begin
         e.bcd[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      e.dp  = w[23] ? 3'd4 : 3'd3;
      e.rng = w[23:22];
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every valid pulse must match the oldest queued expectation.
   always @(negedge clk_sys) begin : monitor
      exp_t e;
      if (bcd_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedValid", {31'd0, bcd_valid}, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("bcdOut", {4'd0, bcd_out}, {4'd0, e.bcd});
            checkOutput("dpPos", {29'd0, dp_pos}, {29'd0, e.dp});
            checkOutput("rangeOut", {30'd0, range_out}, {30'd0, e.rng});
            lastBcd = e.bcd;
         end
      end
   end

   task automatic applyStimulus(input logic [23:0] w, input bit conv);
      @(negedge clk_sys);
      data_in = w;
      if (conv) expQ.push_back(model(w));
   endtask

   task automatic waitBusy(output int capCyc);
      capCyc = -1;
      for (int i = 0; i < 300; i++) begin
         if (busy === 1'b1) begin
            capCyc = cyc;
            break;
         end
         @(negedge clk_sys);
      end
      checkOutput("busyRise", {31'd0, busy}, 32'd1);
   endtask

   task automatic waitValid(output int doneCyc);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         if (bcd_valid === 1'b1) break;
      end
      checkOutput("validRise", {31'd0, bcd_valid}, 32'd1);
      doneCyc = cyc;
   endtask

   task automatic runConversion(input logic [23:0] w, input int prevDone, output int doneOut);
      int cap;
      applyStimulus(w, 1'b1);
      waitBusy(cap);
      if (prevDone >= 0) checkOutput("holdSpacing", 32'(cap - prevDone), 32'(HOLD) + 32'd1);
      waitValid(doneOut);
      checkOutput("latency", 32'(doneOut - cap), 32'd23);
      @(negedge clk_sys);
      checkOutput("validWidth", {31'd0, bcd_valid}, 32'd0);
      checkOutput("outputHeld", {4'd0, bcd_out}, {4'd0, lastBcd});
   endtask

   initial begin
      int done;
      int cap;
      logic [23:0] w;

      // Reset values, then a zero word must never start a conversion.
      @(negedge clk_sys);
      @(negedge clk_sys);
      checkOutput("rstBcd", {4'd0, bcd_out}, 32'd0);
      checkOutput("rstDp", {29'd0, dp_pos}, 32'd0);
      checkOutput("rstRange", {30'd0, range_out}, 32'd0);
      checkOutput("rstValid", {31'd0, bcd_valid}, 32'd0);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_sys);
         checkOutput("idleBcd", {4'd0, bcd_out}, 32'd0);
         checkOutput("idleBusy", {31'd0, busy}, 32'd0);
         checkOutput("idleValid", {31'd0, bcd_valid}, 32'd0);
      end

      runConversion({2'b00, 22'd13141}, -1, done);
      runConversion({2'b10, 22'd4194303}, done, done);

      // A change during SHIFT is deferred until the hold time has expired.
      applyStimulus({2'b00, 22'd100}, 1'b1);
      waitBusy(cap);
      repeat (10) @(negedge clk_sys);
      data_in = {2'b00, 22'd999};
      expQ.push_back(model(data_in));
      waitValid(done);
      checkOutput("latency100", 32'(done - cap), 32'd23);
      waitBusy(cap);
      checkOutput("deferredSpacing", 32'(cap - done), 32'(HOLD) + 32'd1);
      waitValid(done);
      checkOutput("latency999", 32'(done - cap), 32'd23);

      // Reset in mid-SHIFT clears outputs at once; the word is then re-converted.
      applyStimulus({2'b00, 22'd5000}, 1'b1);
      waitBusy(cap);
      repeat (12) @(negedge clk_sys);
      rst = 1'b1;
      #1;
      checkOutput("midRstBcd", {4'd0, bcd_out}, 32'd0);
      checkOutput("midRstDp", {29'd0, dp_pos}, 32'd0);
      checkOutput("midRstRange", {30'd0, range_out}, 32'd0);
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstValid", {31'd0, bcd_valid}, 32'd0);
      expQ.delete();
      expQ.push_back(model(data_in));
      @(negedge clk_sys);
      rst = 1'b0;
      waitBusy(cap);
      waitValid(done);
      checkOutput("latencyAfterRst", 32'(done - cap), 32'd23);

      // Random words, including the range codes 01 and 11 that pass straight through.
      for (int n = 0; n < 8; n++) begin
         do begin
            w = {2'($urandom_range(3, 0)), 22'($urandom_range(4194303, 0))};
         end while (w == data_in);
         runConversion(w, done, done);
      end

      repeat (5) @(negedge clk_sys);
      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
